matrix_sync_master: RTL

- Initiator end of the inter-tile matrix sync serial link.
- On request, raises sync_active, generates WIDTH+1 sync_clk pulses, shifts out a latched cell row plus edge bit, and shifts in the neighbour's row plus edge bit.
- Sits at the tile boundary next to the grid controller; drives the $syn pins that the neighbour's sync responder receives.
- Parallel results are presented once per transfer with a done pulse.

---
 rtl/matrix_sync_master.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/matrix_sync_master.sv
// Initiator end of the inter-tile matrix sync serial link.
// Sends a latched row plus edge bit and captures the neighbour's.
module matrix_sync_master #(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  input  logic [WIDTH-1:0] i_cells,
  input  logic             i_edge,
  output logic [WIDTH-1:0] o_cells,
  output logic             o_edge,
  output logic             o_sync_clk_syn,
  output logic             o_sync_active_syn,
  output logic             o_sync_out_syn,
  input  logic             i_sync_in_syn
);

  localparam int N  = WIDTH + 1;
  localparam int HW = $clog2(HALF_PERIOD);
  localparam int PW = $clog2(N + 1);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] P_LAST = PW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_COOL
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [HW-1:0]  r_hcnt, w_hcnt_nxt;
  logic [PW-1:0]  r_pcnt, w_pcnt_nxt;
  logic [N-1:0]   r_tx, w_tx_nxt;
  logic [N-1:0]   r_rx, w_rx_nxt;
  logic           w_load, w_last;
  logic           r_sync1, r_sync2;
  logic [WIDTH-1:0] r_cells;
  logic           r_edge;
  logic           r_busy, r_done, r_sclk, r_act, r_sout;
  logic           w_act_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_sync_in_syn;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt + 1'b1;
    w_pcnt_nxt  = r_pcnt;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_load      = 1'b0;
    w_last      = (r_hcnt == H_LAST);
    unique case (r_state)
      S_IDLE: begin
        w_hcnt_nxt = '0;
        if (i_start) begin
          w_state_nxt = S_SETUP;
          w_tx_nxt    = {i_edge, i_cells};
          w_pcnt_nxt  = '0;
        end
      end
      S_SETUP: begin
        if (w_last) begin
          w_state_nxt = S_HIGH;
          w_hcnt_nxt  = '0;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_state_nxt = S_LOW;
          w_hcnt_nxt  = '0;
          w_tx_nxt    = r_tx >> 1;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_hcnt_nxt = '0;
          w_rx_nxt   = {r_sync2, r_rx[N-1:1]};
          w_pcnt_nxt = r_pcnt + 1'b1;
          if (r_pcnt == P_LAST) begin
            w_state_nxt = S_COOL;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_HIGH;
          end
        end
      end
      S_COOL: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_hcnt_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_hcnt_nxt  = '0;
      end
    endcase
    w_act_nxt = (w_state_nxt == S_SETUP) ||
                (w_state_nxt == S_HIGH) ||
                (w_state_nxt == S_LOW);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hcnt  <= '0;
      r_pcnt  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_cells <= '0;
      r_edge  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_act   <= 1'b0;
      r_sout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      if (w_load) begin
        r_cells <= w_rx_nxt[WIDTH-1:0];
        r_edge  <= w_rx_nxt[N-1];
      end
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_COOL) && (w_hcnt_nxt == H_LAST);
      r_sclk <= (w_state_nxt == S_HIGH);
      r_act  <= w_act_nxt;
      r_sout <= w_act_nxt & w_tx_nxt[0];
    end
  end

  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_cells           = r_cells;
  assign o_edge            = r_edge;
  assign o_sync_clk_syn    = r_sclk;
  assign o_sync_active_syn = r_act;
  assign o_sync_out_syn    = r_sout;

endmodule
